// File: rtl/wddl_phase_sequencer.sv
// Precharge/evaluate sequencer for a group of WDDL tiles sharing one precharge net,
// with sticky F_ctrl fault aggregation and a threshold alarm that parks the group in spacer.
module wddl_phase_sequencer #(
    parameter int N_TILES      = 8,
    parameter int LEN_W        = 8,
    parameter int CNT_W        = 4,
    parameter int PRECH_CYCLES = 1,
    parameter int EVAL_CYCLES  = 1,
    parameter int CHECK_DLY    = 2,
    parameter int FAULT_THRESH = 2
) (
    input  logic               UserCLK,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   op_len,
    input  logic [N_TILES-1:0] tile_mask,
    input  logic [N_TILES-1:0] fault_in,
    input  logic               clear_alarm,
    output logic               precharge,
    output logic               eval_en,
    output logic               busy,
    output logic               done,
    output logic               alarm,
    output logic [N_TILES-1:0] fault_flags,
    output logic [CNT_W-1:0]   fault_cnt
);

    localparam int MAX_PE   = (PRECH_CYCLES > EVAL_CYCLES) ? PRECH_CYCLES : EVAL_CYCLES;
    localparam int MAX_HOLD = (MAX_PE > CHECK_DLY) ? MAX_PE : CHECK_DLY;
    localparam int TMR_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [TMR_W-1:0] PRECH_LAST = TMR_W'(PRECH_CYCLES - 1);
    localparam logic [TMR_W-1:0] EVAL_LAST  = TMR_W'(EVAL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(CHECK_DLY - 1);
    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(FAULT_THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECH,
        S_EVAL,
        S_DRAIN,
        S_ALARM
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [CHECK_DLY-1:0] sr_q, sr_d;
    logic                 done_q, done_d;
    logic [N_TILES-1:0]   flags_q, flags_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_TILES-1:0]   hit;
    logic [CHECK_DLY:0]   sr_ext;
    logic                 chk;
    logic                 busy_st;

    assign chk     = sr_q[CHECK_DLY-1];
    assign busy_st = (state_q == S_PRECH) || (state_q == S_EVAL) || (state_q == S_DRAIN);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        hit     = fault_in & tile_mask;
        sr_ext  = '0;
        sr_d    = '0;

        // Rails are only meaningful CHECK_DLY cycles after an evaluate cycle.
        if (chk && (hit != '0)) begin
            flags_d = flags_q | hit;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    flags_d = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    if (op_len != '0) begin
                        rem_d   = op_len;
                        state_d = S_PRECH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_PRECH: begin
                if (tmr_q == PRECH_LAST) begin
                    tmr_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_EVAL: begin
                if (tmr_q == EVAL_LAST) begin
                    tmr_d   = '0;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == LEN_W'(1)) ? S_DRAIN : S_PRECH;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (tmr_q == DRAIN_LAST) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_ALARM: begin
                if (clear_alarm) begin
                    state_d = S_IDLE;
                    flags_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase

        // Threshold wins over every busy-state transition, including the done handoff.
        if (busy_st && (cnt_d >= THRESH)) begin
            state_d = S_ALARM;
            tmr_d   = '0;
            done_d  = 1'b0;
        end

        sr_ext = {sr_q, (state_q == S_EVAL)};
        sr_d   = (state_d == S_ALARM) ? '0 : sr_ext[CHECK_DLY-1:0];
    end

    always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            rem_q   <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign precharge   = (state_q != S_EVAL);
    assign eval_en     = (state_q == S_EVAL);
    assign busy        = busy_st;
    assign alarm       = (state_q == S_ALARM);
    assign done        = done_q;
    assign fault_flags = flags_q;
    assign fault_cnt   = cnt_q;

endmodule

// File: tb/tb_wddl_phase_sequencer.sv
// Scoreboard bench for wddl_phase_sequencer: per-operation schedule model pushes expected
// per-cycle phases and completion events; a negedge monitor pops and compares.
module tb_wddl_phase_sequencer;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int CW = 4;
    localparam int P  = 1;
    localparam int E  = 1;
    localparam int D  = 2;
    localparam int TH = 2;

    logic          UserCLK = 1'b0;
    logic          rst, start, clear_alarm;
    logic [LW-1:0] op_len;
    logic [N-1:0]  tile_mask, fault_in;
    logic          precharge, eval_en, busy, done, alarm;
    logic [N-1:0]  fault_flags;
    logic [CW-1:0] fault_cnt;

    wddl_phase_sequencer #(
        .N_TILES(N), .LEN_W(LW), .CNT_W(CW), .PRECH_CYCLES(P),
        .EVAL_CYCLES(E), .CHECK_DLY(D), .FAULT_THRESH(TH)
    ) dut (
        .UserCLK(UserCLK), .rst(rst), .start(start), .op_len(op_len),
        .tile_mask(tile_mask), .fault_in(fault_in), .clear_alarm(clear_alarm),
        .precharge(precharge), .eval_en(eval_en), .busy(busy), .done(done),
        .alarm(alarm), .fault_flags(fault_flags), .fault_cnt(fault_cnt)
    );

    always #5 UserCLK = ~UserCLK;

    int cyc = 0;
    always @(posedge UserCLK) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        bit           pre, ev, bsy, dn, alm;
        logic [N-1:0] flg;
        logic [CW-1:0] cnt;
    } ph_t;

    typedef struct {
        int           cyc;
        bit           is_alarm;
        logic [N-1:0] flg;
        logic [CW-1:0] cnt;
    } ev_t;

    ph_t ph_q[$];
    ev_t ev_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [N-1:0]  fpat [64];
    logic [N-1:0]  prev_flg = '0;
    int            prev_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // r-th cycle after the start cycle is an evaluate cycle of an op of length len
    function automatic bit is_eval(input int r, input int len);
        int q, m;
        if (r < 1) return 1'b0;
        q = (r - 1) / (P + E);
        m = (r - 1) % (P + E);
        return (q < len) && (m >= P);
    endfunction

    // Monitor
    bit alarm_prev = 1'b0;
    always @(negedge UserCLK) begin
        ph_t p;
        ev_t v;
        logic [12:0] a, x;
        while (ph_q.size() > 0 && ph_q[0].cyc <= cyc) begin
            p = ph_q.pop_front();
            a = {precharge, eval_en, busy, done, alarm, fault_flags, fault_cnt};
            x = {p.pre, p.ev, p.bsy, p.dn, p.alm, p.flg, p.cnt};
            check($sformatf("phase_c%0d", p.cyc), int'(a), int'(x));
        end
        if (done || (alarm && !alarm_prev)) begin
            if (ev_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual done=%0b alarm=%0b required none (c%0d)",
                         done, alarm, cyc);
            end else begin
                v = ev_q.pop_front();
                check("event_kind", int'(alarm), int'(v.is_alarm));
                check("event_cycle", cyc, v.cyc);
                check("event_flags", int'(fault_flags), int'(v.flg));
                check("event_cnt", int'(fault_cnt), int'(v.cnt));
            end
        end
        alarm_prev = alarm;
    end

    task automatic fill(input logic [N-1:0] val);
        for (int i = 0; i < 64; i++) fpat[i] = val;
    endtask

    task automatic run_op(input int len, input logic [N-1:0] mask, input int xs_r,
                          input int xs_len, input int clr_off);
        int base, end_r, alarm_r, clr_r, total, cnt;
        logic [N-1:0] flg, hit;
        int rc [64];
        logic [N-1:0] rf [64];
        bit alarmed, alm, bsy, ev, dn;
        ph_t p;
        ev_t v;
        base    = cyc;
        end_r   = (len > 0) ? len * (P + E) + D + 1 : 1;
        cnt     = prev_cnt;
        flg     = prev_flg;
        alarmed = 1'b0;
        alarm_r = -1;
        clr_r   = -1;
        for (int r = 0; r < 64; r++) begin
            rc[r] = cnt;
            rf[r] = flg;
            if (r == 0 || r == clr_r) begin
                cnt = 0;
                flg = '0;
            end else if (!alarmed && is_eval(r - D, len)) begin
                hit = fpat[r] & mask;
                if (hit != '0) begin
                    flg |= hit;
                    if (cnt < (1 << CW) - 1) cnt++;
                    if (cnt >= TH) begin
                        alarmed = 1'b1;
                        alarm_r = r + 1;
                        clr_r   = alarm_r + clr_off;
                    end
                end
            end
        end
        total = alarmed ? clr_r + 2 : end_r + 2;
        for (int r = 0; r <= total; r++) begin
            alm   = alarmed && r >= alarm_r && r <= clr_r;
            bsy   = r >= 1 && r < end_r && !(alarmed && r >= alarm_r);
            ev    = bsy && is_eval(r, len);
            dn    = !alarmed && r == end_r;
            p.cyc = base + r; p.pre = !ev; p.ev = ev; p.bsy = bsy; p.dn = dn; p.alm = alm;
            p.flg = rf[r]; p.cnt = CW'(rc[r]);
            ph_q.push_back(p);
        end
        v.is_alarm = alarmed;
        v.cyc      = base + (alarmed ? alarm_r : end_r);
        v.flg      = rf[alarmed ? alarm_r : end_r];
        v.cnt      = CW'(rc[alarmed ? alarm_r : end_r]);
        ev_q.push_back(v);
        for (int r = 0; r <= total; r++) begin
            start       = (r == 0) || (r == xs_r);
            op_len      = (r == 0) ? LW'(len) : LW'(xs_len);
            tile_mask   = mask;
            fault_in    = fpat[r];
            clear_alarm = alarmed && (r == clr_r);
            @(posedge UserCLK);
            #1;
        end
        start       = 1'b0;
        clear_alarm = 1'b0;
        fault_in    = '0;
        prev_cnt    = cnt;
        prev_flg    = flg;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len, xs_r;
        logic [N-1:0] m;
        rst = 1'b0; start = 1'b0; clear_alarm = 1'b0;
        op_len = '0; tile_mask = '0; fault_in = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_precharge", int'(precharge), 1);
        check("rst_eval_en", int'(eval_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_flags", int'(fault_flags), 0);
        check("rst_cnt", int'(fault_cnt), 0);
        repeat (2) @(posedge UserCLK);
        #1 rst = 1'b0;
        @(posedge UserCLK);
        #1;

        fill('0); run_op(3, 4'hF, -1, 0, 1);
        fill('0); fpat[6] = 4'b0100; run_op(3, 4'hF, -1, 0, 1);
        fill('0); fpat[4] = 4'b0001; fpat[6] = 4'b0001; run_op(3, 4'hF, 10, 3, 5);
        fill(4'b0010); run_op(3, 4'b1101, -1, 0, 1);
        fill('0); fpat[1] = 4'hF; fpat[3] = 4'hF; fpat[5] = 4'hF; run_op(3, 4'hF, -1, 0, 1);
        fill('0); run_op(0, 4'hF, -1, 0, 1);
        fill('0); run_op(2, 4'hF, 3, 4, 1);

        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(0, 5);
            m   = N'($urandom);
            for (int i = 0; i < 64; i++)
                fpat[i] = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            xs_r = (len > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : -1;
            run_op(len, m, xs_r, $urandom_range(0, 5), $urandom_range(1, 4));
        end

        // asynchronous reset in the middle of an evaluate cycle
        start = 1'b1; op_len = LW'(3); tile_mask = 4'hF; fault_in = '0;
        @(posedge UserCLK);
        #1 start = 1'b0;
        repeat (3) @(posedge UserCLK);
        #1;
        check("pre_rst_eval_en", int'(eval_en), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_precharge", int'(precharge), 1);
        check("midrst_eval_en", int'(eval_en), 0);
        check("midrst_busy", int'(busy), 0);
        @(posedge UserCLK);
        #1 rst = 1'b0;
        repeat (12) @(posedge UserCLK);
        #1;
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_cnt", int'(fault_cnt), 0);
        prev_cnt = 0;
        prev_flg = '0;

        check("event_queue_drained", ev_q.size(), 0);
        check("phase_queue_drained", ph_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
